iob_xbar_arb: RTL

//   Parametrised successor to the single-master address split: N native-bus masters share
//   M slaves through one round-robin arbiter and an address decoder.

---
 rtl/iob_xbar_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/iob_xbar_arb.sv
// iob_xbar_arb: N-master / M-slave native-bus crossbar with a single
// round-robin arbiter, address decode, unmapped-error path and watchdog.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   m_req     N_MASTERS x {valid, addr, wdata, wstrb}, master 0 in LSBs
//   m_resp    N_MASTERS x {rdata, ready}, ready in the LSB
//   s_req     N_SLAVES  x {valid, addr, wdata, wstrb}, slave 0 in LSBs
//   s_resp    N_SLAVES  x {rdata, ready}
//   err       sticky flag: unmapped access or timeout seen
//   err_clr   clears err; a coincident new error wins
module iob_xbar_arb #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_MSB   = 31,
  parameter int TIMEOUT   = 255,
  localparam int SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W   = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [N_SLAVES*REQ_W-1:0]     s_req,
  input  logic [N_SLAVES*RESP_W-1:0]    s_resp,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int GNT_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  // LSB of the slave-select field inside a packed request
  localparam int SEL_LSB = DATA_W + DATA_W / 8 + SEL_MSB - SEL_W + 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]        state;
  logic [GNT_W-1:0]  gnt;
  logic [GNT_W-1:0]  rr_ptr;
  logic [GNT_W-1:0]  pick;
  logic [GNT_W-1:0]  gnt_nxt;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  pick_sel;
  logic [15:0]       count;
  logic              any_valid;
  logic              mapped;
  logic              s_ready;
  logic              timeout;
  logic [REQ_W-1:0]  m_cur;
  logic [RESP_W-1:0] s_cur;

  // Round-robin search: walk down so the master nearest rr_ptr wins.
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_MASTERS;
      if (m_req[idx*REQ_W+REQ_W-1]) begin
        any_valid = 1'b1;
        pick      = GNT_W'(idx);
      end
    end
  end

  assign pick_sel = m_req[int'(pick)*REQ_W+SEL_LSB +: SEL_W];
  assign mapped   = int'(pick_sel) < N_SLAVES;

  always_comb begin
    m_cur = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt == GNT_W'(i)) m_cur = m_req[i*REQ_W +: REQ_W];
    end
  end

  always_comb begin
    s_cur = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel == SEL_W'(i)) s_cur = s_resp[i*RESP_W +: RESP_W];
    end
  end

  assign s_ready = (state == BUSY) && s_cur[0];
  // A ready on the last watchdog cycle is a normal completion.
  assign timeout = (state == BUSY) && !s_cur[0]
                && (count == TO_LAST);
  assign gnt_nxt = (gnt == GNT_W'(N_MASTERS - 1))
                 ? '0 : gnt + GNT_W'(1);

  always_comb begin
    s_req = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (state == BUSY && !timeout && sel == SEL_W'(i))
        s_req[i*REQ_W +: REQ_W] = m_cur;
    end
  end

  always_comb begin
    m_resp = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt == GNT_W'(i)) begin
        if (s_ready)
          m_resp[i*RESP_W +: RESP_W] = s_cur;
        else if (timeout || state == ERR)
          m_resp[i*RESP_W +: RESP_W] = RESP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      sel    <= '0;
      rr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      // Error set below overrides this clear.
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            gnt   <= pick;
            sel   <= pick_sel;
            count <= '0;
            state <= mapped ? BUSY : ERR;
          end
        end
        BUSY: begin
          if (s_cur[0]) begin
            rr_ptr <= gnt_nxt;
            count  <= '0;
            state  <= IDLE;
          end else if (count == TO_LAST) begin
            err    <= 1'b1;
            rr_ptr <= gnt_nxt;
            count  <= '0;
            state  <= IDLE;
          end else begin
            count <= count + 16'd1;
          end
        end
        ERR: begin
          err    <= 1'b1;
          rr_ptr <= gnt_nxt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
